data_bus_ctrl: RTL and testbench



---
 rtl/data_bus_ctrl.sv | 158 +++++++++++++++
 tb/tb_data_bus_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_ctrl.sv
// Data-side bus controller: decodes core loads/stores to the data SRAM or the UART TX FIFO,
// drives SRAM byte lanes and returns formatted load data with a fixed two-cycle latency.
module data_bus_ctrl #(
    parameter int unsigned RAM_AW     = 12,
    parameter logic [31:0] UART_BASE  = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic [31:0]       dataBusOut,
    input  logic              wrEn,
    input  logic              rdEn,
    input  logic [3:0]        RamMode,
    output logic [31:0]       dataBusIn,
    output logic              dataBusInEn,
    output logic              misalign_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // RamMode = {byte, half, word, unsigned}
    logic isByte, isHalf, isUns;
    logic misaligned, access, doStore, doLoad;
    logic ramHit, uartHit;

    assign isByte     = RamMode[3];
    assign isHalf     = RamMode[2];
    assign isUns      = RamMode[0];
    assign misaligned = (isHalf & addr[0]) | (RamMode[1] & (|addr[1:0]));
    assign access     = wrEn | rdEn;
    assign doStore    = wrEn & ~misaligned;
    // A simultaneous store takes priority and suppresses the load entirely.
    assign doLoad     = rdEn & ~wrEn;
    assign ramHit     = (addr[31:RAM_AW+2] == '0);
    assign uartHit    = (addr[31:3] == UART_BASE[31:3]);

    // SRAM request path, combinational from the core request.
    always_comb begin
        ram_en    = access & ~misaligned & ramHit;
        ram_we    = doStore & ramHit;
        ram_addr  = addr[RAM_AW+1:2];
        ram_be    = 4'h0;
        ram_wdata = dataBusOut;
        if (isByte) begin
            ram_wdata = {4{dataBusOut[7:0]}};
            if (ram_we) ram_be = 4'b0001 << addr[1:0];
        end else if (isHalf) begin
            ram_wdata = {2{dataBusOut[15:0]}};
            if (ram_we) ram_be = addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            if (ram_we) ram_be = 4'hF;
        end
    end

    // UART TX FIFO
    logic [7:0]      fifoMem [FIFO_DEPTH];
    logic [PtrW-1:0] wrPtrQ, rdPtrQ;
    logic [CntW-1:0] countQ;
    logic            overflowQ;
    logic            push, pop, pushOk, full, empty, statusRd;
    logic [31:0]     statusVal;

    assign full     = (countQ == CntW'(FIFO_DEPTH));
    assign empty    = (countQ == '0);
    assign tx_valid = ~empty;
    assign tx_data  = fifoMem[rdPtrQ];
    assign pop      = tx_valid & tx_ready;
    assign push     = doStore & uartHit & ~addr[2];
    assign pushOk   = push & (~full | pop);
    assign statusRd = doLoad & ~misaligned & uartHit & addr[2];

    always_comb begin
        statusVal             = '0;
        statusVal[CntW+3:4]   = countQ;
        statusVal[2]          = overflowQ;
        statusVal[1]          = empty;
        statusVal[0]          = full;
    end

    always_ff @(posedge clk) begin
        if (pushOk) fifoMem[wrPtrQ] <= dataBusOut[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            countQ    <= '0;
            overflowQ <= 1'b0;
        end else begin
            if (pushOk) wrPtrQ <= wrPtrQ + 1'b1;
            if (pop)    rdPtrQ <= rdPtrQ + 1'b1;
            countQ <= countQ + CntW'(pushOk) - CntW'(pop);
            if (push && !pushOk) overflowQ <= 1'b1;
            else if (statusRd)   overflowQ <= 1'b0;
        end
    end

    // Load pipeline: request stage captures target info, response stage formats data.
    logic        ldValidQ, ldRamQ, ldByteQ, ldHalfQ, ldUnsQ;
    logic [1:0]  ldOffQ;
    logic [31:0] ldImmQ;
    logic [31:0] laneData, fmtData;

    always_ff @(posedge clk) begin
        if (rst) begin
            ldValidQ     <= 1'b0;
            ldRamQ       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            ldValidQ     <= doLoad;
            ldRamQ       <= doLoad & ~misaligned & ramHit;
            misalign_err <= access & misaligned;
        end
        ldByteQ <= isByte;
        ldHalfQ <= isHalf;
        ldUnsQ  <= isUns;
        ldOffQ  <= addr[1:0];
        ldImmQ  <= statusRd ? statusVal : 32'h0;
    end

    always_comb begin
        laneData = ram_rdata >> {ldOffQ, 3'b000};
        fmtData  = ldImmQ;
        if (ldRamQ) begin
            if (ldByteQ) begin
                fmtData = {{24{~ldUnsQ & laneData[7]}}, laneData[7:0]};
            end else if (ldHalfQ) begin
                laneData = ldOffQ[1] ? {16'h0, ram_rdata[31:16]} : {16'h0, ram_rdata[15:0]};
                fmtData  = {{16{~ldUnsQ & laneData[15]}}, laneData[15:0]};
            end else begin
                fmtData = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dataBusIn   <= 32'h0;
            dataBusInEn <= 1'b0;
        end else begin
            dataBusInEn <= ldValidQ;
            if (ldValidQ) dataBusIn <= fmtData;
        end
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Scoreboard bench for data_bus_ctrl: directed loads/stores against a behavioural SRAM,
// with separate monitors checking load responses (data and latency) and UART TX bytes.
module tb_data_bus_ctrl;

    localparam logic [31:0] UART  = 32'h1000_0000;
    localparam logic [31:0] STAT  = 32'h1000_0004;
    localparam logic [3:0]  MB    = 4'b1000;
    localparam logic [3:0]  MBU   = 4'b1001;
    localparam logic [3:0]  MH    = 4'b0100;
    localparam logic [3:0]  MHU   = 4'b0101;
    localparam logic [3:0]  MW    = 4'b0010;

    logic        clk, rst;
    logic [31:0] addr, dataBusOut, dataBusIn, ram_wdata, ram_rdata;
    logic        wrEn, rdEn, dataBusInEn, misalign_err, ram_en, ram_we, tx_valid, tx_ready;
    logic [3:0]  RamMode, ram_be;
    logic [11:0] ram_addr;
    logic [7:0]  tx_data;

    data_bus_ctrl dut (
        .clk(clk), .rst(rst), .addr(addr), .dataBusOut(dataBusOut), .wrEn(wrEn), .rdEn(rdEn),
        .RamMode(RamMode), .dataBusIn(dataBusIn), .dataBusInEn(dataBusInEn),
        .misalign_err(misalign_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous SRAM
    logic [31:0] sram [4096];
    initial for (int i = 0; i < 4096; i++) sram[i] = 32'h0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int l = 0; l < 4; l++)
                    if (ram_be[l]) sram[ram_addr][l*8 +: 8] <= ram_wdata[l*8 +: 8];
            end else begin
                ram_rdata <= sram[ram_addr];
            end
        end
    end

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [31:0] d;
        int          due;
    } ld_exp_t;

    ld_exp_t     ldQ[$];
    logic [7:0]  txQ[$];

    // Load response monitor
    always @(negedge clk) begin
        ld_exp_t e;
        if (ldQ.size() > 0 && ldQ[0].due < cyc) begin
            e = ldQ.pop_front();
            tests++; fails++;
            $display("FAIL load_missing: no response by cycle %0d, expected data %h", e.due, e.d);
        end
        if (dataBusInEn === 1'b1) begin
            if (ldQ.size() == 0) begin
                tests++; fails++;
                $display("FAIL load_unexpected: got %h at cycle %0d, required none", dataBusIn, cyc);
            end else begin
                e = ldQ.pop_front();
                check("load_data", dataBusIn, e.d);
                check("load_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // UART TX monitor
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (txQ.size() == 0) begin
                tests++; fails++;
                $display("FAIL tx_unexpected: got %h, required none", tx_data);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, txQ.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        wrEn = 1'b1; rdEn = 1'b0; addr = a; dataBusOut = d; RamMode = m;
        @(posedge clk); #1;
        wrEn = 1'b0;
    endtask

    task automatic storeChk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            input logic expWe, input logic [3:0] expBe,
                            input logic [31:0] expWdata);
        wrEn = 1'b1; rdEn = 1'b0; addr = a; dataBusOut = d; RamMode = m;
        #1;
        check("ram_we", {31'h0, ram_we}, {31'h0, expWe});
        check("ram_be", {28'h0, ram_be}, {28'h0, expBe});
        if (expWe) check("ram_wdata", ram_wdata, expWdata);
        @(posedge clk); #1;
        wrEn = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] m, input logic [31:0] exp);
        rdEn = 1'b1; wrEn = 1'b0; addr = a; RamMode = m;
        ldQ.push_back('{exp, cyc + 2});
        @(posedge clk); #1;
        rdEn = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        tx_ready = 1'b1;
        while (tx_valid && n < 20) begin @(posedge clk); #1; n++; end
        tx_ready = 1'b0;
        check("drain_done", {31'h0, tx_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; addr = '0; dataBusOut = '0;
        RamMode = MW; tx_ready = 1'b0;
        idle(2);
        rst = 1'b0;
        check("rst_dataBusInEn", {31'h0, dataBusInEn}, 32'h0);
        check("rst_dataBusIn", dataBusIn, 32'h0);
        check("rst_misalign", {31'h0, misalign_err}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);

        // Word store then byte/half loads with extension
        storeChk(32'h10, 32'hDEAD_BEEF, MW, 1'b1, 4'hF, 32'hDEAD_BEEF);
        load(32'h13, MB,  32'hFFFF_FFDE);
        load(32'h13, MBU, 32'h0000_00DE);
        load(32'h12, MHU, 32'h0000_DEAD);
        @(negedge clk);
        check("no_misalign", {31'h0, misalign_err}, 32'h0);
        @(posedge clk); #1;

        // Halfword store merges into existing word
        store(32'h20, 32'hCAFE_F00D, MW);
        storeChk(32'h22, 32'h0000_1234, MH, 1'b1, 4'b1100, 32'h1234_1234);
        storeChk(32'h27, 32'h0000_00A5, MB, 1'b1, 4'b1000, 32'hA5A5_A5A5);
        load(32'h20, MW, 32'h1234_F00D);
        load(32'h21, MB, 32'hFFFF_FFF0);
        load(32'h22, MH, 32'h0000_1234);
        load(32'h24, MW, 32'hA500_0000);

        // Misaligned load and store
        load(32'h21, MW, 32'h0);
        @(negedge clk);
        check("misalign_load", {31'h0, misalign_err}, 32'h1);
        @(posedge clk); #1;
        storeChk(32'h22, 32'h5555_5555, MW, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("misalign_store", {31'h0, misalign_err}, 32'h1);
        @(posedge clk); #1;
        load(32'h20, MW, 32'h1234_F00D);

        // Unmapped and TXDATA loads return zero
        load(32'h2000_0000, MW, 32'h0);
        load(UART, MW, 32'h0);
        idle(3);

        // FIFO overflow and status
        for (int i = 0; i < 5; i++) begin
            store(UART, 32'h41 + i, MB);
            if (i < 4) txQ.push_back(8'(8'h41 + i));
        end
        load(STAT, MW, 32'h0000_0045);
        load(STAT, MW, 32'h0000_0041);
        idle(3);
        drain();
        load(STAT, MW, 32'h0000_0002);
        idle(3);

        // Push while full with simultaneous pop is accepted
        for (int i = 0; i < 4; i++) begin
            store(UART, 32'h51 + i, MB);
            txQ.push_back(8'(8'h51 + i));
        end
        tx_ready = 1'b1;
        store(UART, 32'h55, MB);
        txQ.push_back(8'h55);
        tx_ready = 1'b0;
        load(STAT, MW, 32'h0000_0041);
        idle(3);
        drain();
        idle(2);

        // Reset during an in-flight load cancels the response
        for (int i = 0; i < 5; i++) store(UART, 32'h61 + i, MB);
        rdEn = 1'b1; addr = 32'h10; RamMode = MW;
        @(posedge clk); #1;
        rdEn = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cancel_en", {31'h0, dataBusInEn}, 32'h0);
        check("rst_fifo_empty", {31'h0, tx_valid}, 32'h0);
        @(posedge clk); #1;
        load(STAT, MW, 32'h0000_0002);
        idle(4);

        check("ld_queue_empty", 32'(ldQ.size()), 32'h0);
        check("tx_queue_empty", 32'(txQ.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
